// File: rtl/sc_lsu_pkg.sv
//------------------------------------------------------------------------------
// Module  : sc_lsu_pkg
// Brief   : Shared funct3 width codes and FSM state encoding for the LSU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package sc_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RMW  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sc_lsu_if.sv
//------------------------------------------------------------------------------
// Module  : sc_lsu_if / sc_lsu_mem_if
// Brief   : Core-side request/response bundle and word-RAM port bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface sc_lsu_if #(parameter int XLEN = 32);
  logic            req;
  logic            wr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            fault;
  logic [XLEN-1:0] rdata;

  modport master (output req, wr, funct3, addr, wdata,
                  input  busy, done, fault, rdata);
  modport slave  (input  req, wr, funct3, addr, wdata,
                  output busy, done, fault, rdata);
endinterface

interface sc_lsu_mem_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_din;
  logic            mem_we;
  logic [XLEN-1:0] mem_dout;

  modport master (output mem_addr, mem_din, mem_we, input mem_dout);
  modport slave  (input  mem_addr, mem_din, mem_we, output mem_dout);
endinterface

`default_nettype wire

// File: rtl/sc_lsu_align.sv
//------------------------------------------------------------------------------
// Module  : sc_lsu_align
// Brief   : Load lane extract with sign/zero extension and store lane merge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sc_lsu_align
  import sc_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_word[{i_off[1], 4'b0000} +: 16];

    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h000000, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase

    // Unaddressed lanes keep the RAM contents so the write-back is a true RMW
    o_merge = i_word;
    if (i_funct3[1:0] == 2'b00) begin
      o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
    end else if (i_funct3[1:0] == 2'b01) begin
      o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sc_lsu.sv
//------------------------------------------------------------------------------
// Module  : sc_lsu
// Brief   : RV32I load/store unit with byte/half RMW stores and fault reporting.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sc_lsu
  import sc_lsu_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int FAULT_ON_MISALIGN = 1
)(
  input  logic          clk,
  input  logic          rst,
  sc_lsu_if.slave       core,
  sc_lsu_mem_if.master  mem
);

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            w_illegal;
  logic            w_misalign;
  logic [XLEN-1:0] w_addr_eff;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_merge_val;
  logic            w_busy, w_done, w_fault, w_we;
  logic [XLEN-1:0] w_mem_addr, w_mem_din;

  assign w_illegal = core.wr ? !(core.funct3 inside {F3_B, F3_H, F3_W})
                             : !(core.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  generate
    if (FAULT_ON_MISALIGN != 0) begin : g_fault_misalign
      assign w_misalign = ((core.funct3[1:0] == 2'b01) && core.addr[0]) ||
                          ((core.funct3[1:0] == 2'b10) && (core.addr[1:0] != 2'b00));
      assign w_addr_eff = core.addr;
    end else begin : g_force_align
      // Word widths drop both low bits, halfword widths drop bit 0
      assign w_misalign = 1'b0;
      assign w_addr_eff = {core.addr[XLEN-1:2],
                           core.funct3[1] ? 2'b00
                                          : {core.addr[1], core.addr[0] & ~core.funct3[0]}};
    end
  endgenerate

  sc_lsu_align u_align (
    .i_word   (mem.mem_dout),
    .i_off    (addr_q[1:0]),
    .i_funct3 (f3_q),
    .i_wdata  (wdata_q[15:0]),
    .o_load   (w_load_val),
    .o_merge  (w_merge_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    w_busy     = (state_q != ST_IDLE);
    w_done     = 1'b0;
    w_fault    = 1'b0;
    w_we       = 1'b0;
    w_mem_addr = '0;
    w_mem_din  = '0;

    if (state_q != ST_IDLE) begin
      w_mem_addr = {addr_q[XLEN-1:2], 2'b00};
    end

    case (state_q)
      ST_IDLE: begin
        if (core.req) begin
          f3_d    = core.funct3;
          addr_d  = w_addr_eff;
          wdata_d = core.wdata;
          if (w_illegal || w_misalign)   state_d = ST_ERR;
          else if (!core.wr)             state_d = ST_LOAD;
          else if (core.funct3 == F3_W)  state_d = ST_WR;
          else                           state_d = ST_RMW;
        end
      end
      ST_LOAD: begin
        rdata_d = w_load_val;
        state_d = ST_DONE;
      end
      ST_RMW: begin
        merge_d = w_merge_val;
        state_d = ST_WR;
      end
      ST_WR: begin
        w_we      = 1'b1;
        w_mem_din = (f3_q == F3_W) ? wdata_q : merge_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        w_done  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        w_done  = 1'b1;
        w_fault = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core.busy    = w_busy;
  assign core.done    = w_done;
  assign core.fault   = w_fault;
  assign core.rdata   = rdata_q;
  assign mem.mem_addr = w_mem_addr;
  assign mem.mem_din  = w_mem_din;
  assign mem.mem_we   = w_we;

endmodule

`default_nettype wire

// File: tb/tb_sc_lsu.sv
//------------------------------------------------------------------------------
// Module  : tb_sc_lsu
// Brief   : Directed bench for sc_lsu with a word-RAM model and cycle compare.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sc_lsu;
  import sc_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  always #5 clk = ~clk;

  sc_lsu_if     core_if ();
  sc_lsu_mem_if mem_if ();

  sc_lsu #(.XLEN(32), .FAULT_ON_MISALIGN(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  // Word RAM with combinational read, preloaded while preload is high
  logic [31:0] ram [0:63];
  assign mem_if.mem_dout = ram[mem_if.mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[20] <= 32'h000000f2;
      ram[21] <= 32'h0000000e;
      ram[22] <= 32'h00000200;
      ram[23] <= 32'hffffffff;
    end else if (mem_if.mem_we) begin
      ram[mem_if.mem_addr[7:2]] <= mem_if.mem_din;
    end
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Driver-owned transaction description
  int          tx_id = 0;
  int          acc_edge = 0;
  logic        e_wr = 1'b0;
  logic        e_fault = 1'b0;
  int          e_lat = 0;
  logic [31:0] e_a = '0;
  logic [31:0] e_word = '0;
  logic [31:0] e_load = '0;
  int          lit_lat = 0;
  logic        lit_fault = 1'b0;
  int          lit_we = 0;
  logic        lit_rd_en = 1'b0;
  logic [31:0] lit_rd = '0;
  int          mem_req_n = 0;
  logic [31:0] mem_chk_a = '0;
  logic [31:0] mem_chk_v = '0;
  logic        sweep_req = 1'b0;
  logic        timeout_seen = 1'b0;

  // Compare-owned state
  int          done_id = 0;
  int          mem_ack_n = 0;
  logic        sweep_done = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] mref [0:63];
  int          we_cnt = 0;
  int          dut_done_k = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural prediction of one access from the RV32I rules
  task automatic model(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd);
    int          sz;
    logic        legal;
    logic [31:0] word, v, mask;
    int          sh;
    sz    = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_wr    = w;
    e_a     = a;
    e_fault = !legal || ((a % sz) != 0);
    word    = mref[a[7:2]];
    sh      = (a % 4) * 8;
    v       = word >> sh;
    case (f)
      3'd0:    e_load = ((v & 32'hff) ^ 32'h80) - 32'h80;
      3'd4:    e_load = v & 32'hff;
      3'd1:    e_load = ((v & 32'hffff) ^ 32'h8000) - 32'h8000;
      3'd5:    e_load = v & 32'hffff;
      default: e_load = word;
    endcase
    mask   = (sz == 1) ? 32'hff : (sz == 2) ? 32'hffff : 32'hffffffff;
    e_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
    e_lat  = e_fault ? 1 : (w && sz < 4) ? 3 : 2;
  endtask

  always @(negedge clk) begin : p_cmp
    int          k;
    logic        act, e_done, e_we;
    logic [31:0] e_addr_x, e_din_x;
    if (preload) begin
      for (int i = 0; i < 64; i++) mref[i] = 32'h0;
      mref[20] = 32'h000000f2;
      mref[21] = 32'h0000000e;
      mref[22] = 32'h00000200;
      mref[23] = 32'hffffffff;
      done_id   = tx_id;
      exp_rdata = '0;
    end else begin
      if (rst) begin
        done_id   = tx_id;
        exp_rdata = '0;
      end
      k        = (tx_id != done_id) ? (edge_n - acc_edge + 1) : 0;
      act      = (k >= 1) && (k <= e_lat);
      e_done   = act && (k == e_lat);
      e_we     = act && e_wr && !e_fault && (k == e_lat - 1);
      e_addr_x = act ? {e_a[31:2], 2'b00} : 32'h0;
      e_din_x  = e_we ? e_word : 32'h0;
      if (k == 1) begin
        we_cnt     = 0;
        dut_done_k = 0;
      end
      if (act && mem_if.mem_we) we_cnt++;
      if (act && core_if.done && dut_done_k == 0) dut_done_k = k;
      if (e_done && !e_fault && !e_wr) exp_rdata = e_load;

      chk("busy",     {31'b0, core_if.busy},  {31'b0, act});
      chk("done",     {31'b0, core_if.done},  {31'b0, e_done});
      chk("mem_we",   {31'b0, mem_if.mem_we}, {31'b0, e_we});
      chk("mem_addr", mem_if.mem_addr, e_addr_x);
      chk("mem_din",  mem_if.mem_din,  e_din_x);
      chk("rdata",    core_if.rdata,   exp_rdata);

      if (e_done) begin
        chk("fault",       {31'b0, core_if.fault}, {31'b0, e_fault});
        chk("latency_lit", dut_done_k, lit_lat);
        chk("fault_lit",   {31'b0, core_if.fault}, {31'b0, lit_fault});
        chk("we_cnt_lit",  we_cnt, lit_we);
        if (lit_rd_en) chk("rdata_lit", core_if.rdata, lit_rd);
        if (e_wr && !e_fault) mref[e_a[7:2]] = e_word;
        done_id = tx_id;
      end

      if (mem_ack_n != mem_req_n) begin
        chk("ram_word_lit", ram[mem_chk_a[7:2]], mem_chk_v);
        mem_ack_n = mem_req_n;
      end

      if (sweep_req && !sweep_done) begin
        for (int i = 16; i < 32; i++) chk("ram_vs_model", ram[i], mref[i]);
        chk("timeout", {31'b0, timeout_seen}, 32'h0);
        sweep_done = 1'b1;
      end
    end
  end

  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input int l_lat,
                       input logic l_fault, input int l_we, input logic l_rd_en,
                       input logic [31:0] l_rd);
    @(negedge clk);
    model(w, f, a, wd);
    lit_lat   = l_lat;
    lit_fault = l_fault;
    lit_we    = l_we;
    lit_rd_en = l_rd_en;
    lit_rd    = l_rd;
    acc_edge  = edge_n + 1;
    tx_id++;
    core_if.req    = 1'b1;
    core_if.wr     = w;
    core_if.funct3 = f;
    core_if.addr   = a;
    core_if.wdata  = wd;
    repeat (hold) @(posedge clk);
    #2 core_if.req = 1'b0;
    for (int i = 0; i < 12 && done_id != tx_id; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_id != tx_id) timeout_seen = 1'b1;
  endtask

  task automatic mem_lit(input logic [31:0] a, input logic [31:0] v);
    mem_chk_a = a;
    mem_chk_v = v;
    mem_req_n++;
    for (int i = 0; i < 4 && mem_ack_n != mem_req_n; i++) begin
      @(negedge clk);
      #1;
    end
    if (mem_ack_n != mem_req_n) timeout_seen = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    preload        = 1'b1;
    core_if.req    = 1'b0;
    core_if.wr     = 1'b0;
    core_if.funct3 = 3'b000;
    core_if.addr   = 32'h0;
    core_if.wdata  = 32'h0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //    wr  f3     addr   wdata        hold lat flt we rd? rdata
    do_op(0, F3_B,  32'h50, 32'h0,        1, 2, 0, 0, 1, 32'hfffffff2);
    do_op(0, F3_BU, 32'h50, 32'h0,        1, 2, 0, 0, 1, 32'h000000f2);
    do_op(0, F3_HU, 32'h5e, 32'h0,        1, 2, 0, 0, 1, 32'h0000ffff);
    do_op(0, F3_H,  32'h5e, 32'h0,        1, 2, 0, 0, 1, 32'hffffffff);
    do_op(1, F3_B,  32'h59, 32'h000000ab, 1, 3, 0, 1, 0, 32'h0);
    mem_lit(32'h58, 32'h0000ab00);
    do_op(0, F3_W,  32'h58, 32'h0,        1, 2, 0, 0, 1, 32'h0000ab00);
    do_op(1, F3_H,  32'h56, 32'h1234beef, 1, 3, 0, 1, 0, 32'h0);
    mem_lit(32'h54, 32'hbeef000e);
    do_op(1, F3_W,  32'h60, 32'hdeadbeef, 1, 2, 0, 1, 0, 32'h0);
    mem_lit(32'h60, 32'hdeadbeef);
    do_op(0, F3_W,  32'h62, 32'h0,        1, 1, 1, 0, 1, 32'h0000ab00);
    do_op(1, F3_H,  32'h53, 32'h00005555, 1, 1, 1, 0, 1, 32'h0000ab00);
    mem_lit(32'h50, 32'h000000f2);
    do_op(0, 3'b011, 32'h50, 32'h0,       1, 1, 1, 0, 1, 32'h0000ab00);
    do_op(1, 3'b100, 32'h50, 32'h000000cc,1, 1, 1, 0, 0, 32'h0);
    mem_lit(32'h50, 32'h000000f2);
    do_op(0, F3_B,  32'h59, 32'h0,        1, 2, 0, 0, 1, 32'hffffffab);
    do_op(1, F3_B,  32'h5d, 32'h00000077, 4, 3, 0, 1, 0, 32'h0);
    mem_lit(32'h5c, 32'hffff77ff);
    do_op(0, F3_W,  32'h5c, 32'h0,        1, 2, 0, 0, 1, 32'hffff77ff);

    // Reset while the byte store sits in its read phase
    @(negedge clk);
    model(1'b1, F3_B, 32'h50, 32'h00000011);
    lit_rd_en = 1'b0;
    acc_edge  = edge_n + 1;
    tx_id++;
    core_if.req    = 1'b1;
    core_if.wr     = 1'b1;
    core_if.funct3 = F3_B;
    core_if.addr   = 32'h50;
    core_if.wdata  = 32'h00000011;
    @(posedge clk);
    #2;
    rst         = 1'b1;
    core_if.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mem_lit(32'h50, 32'h000000f2);

    do_op(0, F3_HU, 32'h54, 32'h0,        1, 2, 0, 0, 1, 32'h0000000e);
    do_op(0, F3_H,  32'h56, 32'h0,        1, 2, 0, 0, 1, 32'hffffbeef);

    sweep_req = 1'b1;
    for (int i = 0; i < 4 && !sweep_done; i++) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
